// File: rtl/overlay_mixer.sv
// Overlay compositing stage: buffers overlay pixels in a show-ahead FIFO and substitutes them
// for the background pixel inside a programmable window, with colour-keyed transparency.
module overlay_mixer #(
  parameter int unsigned hBusWidth     = 12,
  parameter int unsigned vBusWidth     = 12,
  parameter int unsigned overlayWidth  = 320,
  parameter int unsigned overlayHeight = 240,
  parameter int unsigned fifoAddrWidth = 9,
  parameter logic [23:0] keyColour     = 24'hFF00FF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [hBusWidth-1:0]     hCount,
  input  logic [vBusWidth-1:0]     vCount,
  input  logic                     deIn,
  input  logic                     hsyncIn,
  input  logic                     vsyncIn,
  input  logic [23:0]              bgColour,
  input  logic                     overlayEnable,
  input  logic [hBusWidth-1:0]     xOrigin,
  input  logic [vBusWidth-1:0]     yOrigin,
  input  logic [23:0]              ovlData,
  input  logic                     ovlValid,
  output logic                     ovlReady,
  output logic                     ovlFrameStart,
  output logic                     DE,
  output logic                     HSYNC,
  output logic                     VSYNC,
  output logic [23:0]              data,
  output logic [fifoAddrWidth:0]   fifoLevel,
  output logic                     underflow
);

  localparam int unsigned Depth = 2 ** fifoAddrWidth;
  localparam logic [fifoAddrWidth:0] DepthLvl = (fifoAddrWidth + 1)'(Depth);
  localparam logic [hBusWidth:0] OvlW = (hBusWidth + 1)'(overlayWidth);
  localparam logic [vBusWidth:0] OvlH = (vBusWidth + 1)'(overlayHeight);

  typedef enum logic [1:0] {StIdle, StFlush, StRun} state_e;

  state_e state_q, state_d;
  logic   vsync_prev_q;
  logic   vsync_rise;

  logic [fifoAddrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [fifoAddrWidth:0]   level_q;
  logic [23:0]              mem_q [Depth];
  logic [23:0]              head;

  logic              push, pop, clear, in_win, in_x, in_y;
  logic [hBusWidth:0] x_end;
  logic [vBusWidth:0] y_end;
  logic [23:0]        pixel;
  logic               underflow_q;

  assign vsync_rise = vsyncIn & ~vsync_prev_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (vsync_rise) state_d = StFlush;
      StFlush: state_d = StRun;
      StRun:   if (vsync_rise) state_d = StFlush;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      vsync_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_prev_q <= vsyncIn;
    end
  end

  // Sums are one bit wider than the bus so a window past the raster edge cannot wrap.
  assign x_end  = {1'b0, xOrigin} + OvlW;
  assign y_end  = {1'b0, yOrigin} + OvlH;
  assign in_x   = (hCount >= xOrigin) && ({1'b0, hCount} < x_end);
  assign in_y   = (vCount >= yOrigin) && ({1'b0, vCount} < y_end);
  assign in_win = overlayEnable & deIn & in_x & in_y;

  assign ovlReady      = (state_q == StRun) && (level_q < DepthLvl);
  assign ovlFrameStart = (state_q == StFlush);
  assign push          = ovlValid & ovlReady;
  assign pop           = in_win & (level_q != '0) & (state_q == StRun);
  // Pointers are cleared on entry to FLUSH as well, so any word accepted in that cycle is dropped.
  assign clear         = (state_d == StFlush) || (state_q == StFlush);
  assign head          = mem_q[rd_ptr_q];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= ovlData;
  end

  always_comb begin
    pixel = bgColour;
    if (pop && (head != keyColour)) pixel = head;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      DE          <= 1'b0;
      HSYNC       <= 1'b0;
      VSYNC       <= 1'b0;
      data        <= '0;
      underflow_q <= 1'b0;
    end else begin
      DE          <= deIn;
      HSYNC       <= hsyncIn;
      VSYNC       <= vsyncIn;
      data        <= pixel;
      underflow_q <= underflow_q | (in_win & (level_q == '0) & (state_q == StRun));
    end
  end

  assign fifoLevel = level_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_overlay_mixer.sv
// Directed bench for overlay_mixer with a reference model and an output scoreboard.
module tb_overlay_mixer;

  localparam int OW = 4;
  localparam int OH = 2;
  localparam int HPIX = 8;
  localparam int FDEPTH = 8;
  localparam logic [23:0] KEY = 24'hFF00FF;
  localparam logic [23:0] BG = 24'h000010;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] hCount, vCount, xOrigin, yOrigin;
  logic        deIn, hsyncIn, vsyncIn, overlayEnable, ovlValid;
  logic [23:0] bgColour, ovlData, data;
  logic        ovlReady, ovlFrameStart, DE, HSYNC, VSYNC, underflow;
  logic [3:0]  fifoLevel;

  overlay_mixer #(
    .overlayWidth (OW),
    .overlayHeight(OH),
    .fifoAddrWidth(3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .hCount       (hCount),
    .vCount       (vCount),
    .deIn         (deIn),
    .hsyncIn      (hsyncIn),
    .vsyncIn      (vsyncIn),
    .bgColour     (bgColour),
    .overlayEnable(overlayEnable),
    .xOrigin      (xOrigin),
    .yOrigin      (yOrigin),
    .ovlData      (ovlData),
    .ovlValid     (ovlValid),
    .ovlReady     (ovlReady),
    .ovlFrameStart(ovlFrameStart),
    .DE           (DE),
    .HSYNC        (HSYNC),
    .VSYNC        (VSYNC),
    .data         (data),
    .fifoLevel    (fifoLevel),
    .underflow    (underflow)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: 0 idle, 1 flush, 2 run
  int          m_state;
  bit          m_vprev;
  bit          m_uf;
  logic [23:0] m_q[$];
  logic [26:0] sb_q[$];
  int          xo, yo;
  bit          en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    sb_q.delete();
    m_state = 0;
    m_vprev = 1'b0;
    m_uf    = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".out"}, 32'({DE, HSYNC, VSYNC, data}), 32'd0);
    check({tag, ".ready"}, 32'(ovlReady), 32'd0);
    check({tag, ".fstart"}, 32'(ovlFrameStart), 32'd0);
    check({tag, ".level"}, 32'(fifoLevel), 32'd0);
    check({tag, ".uflow"}, 32'(underflow), 32'd0);
  endtask

  task automatic step(input int h, input int v, input bit de, input bit hs, input bit vs,
                      input bit valid, input logic [23:0] wd);
    bit          win, rise, ready, pop;
    logic [23:0] exp_pix;
    logic [26:0] exp_out;
    hCount   = 12'(h);
    vCount   = 12'(v);
    deIn     = de;
    hsyncIn  = hs;
    vsyncIn  = vs;
    ovlValid = valid;
    ovlData  = wd;
    xOrigin  = 12'(xo);
    yOrigin  = 12'(yo);
    overlayEnable = en;
    #0;
    win   = en && de && (h >= xo) && (h < xo + OW) && (v >= yo) && (v < yo + OH);
    rise  = vs && !m_vprev;
    ready = (m_state == 2) && (m_q.size() < FDEPTH);
    pop   = win && (m_q.size() > 0) && (m_state == 2);
    check("ready", 32'(ovlReady), 32'(ready));
    check("fstart", 32'(ovlFrameStart), 32'(m_state == 1));
    if (win && m_q.size() == 0 && m_state == 2) m_uf = 1'b1;
    exp_pix = BG;
    if (pop) begin
      if (m_q[0] != KEY) exp_pix = m_q[0];
      void'(m_q.pop_front());
    end
    if (valid && ready) m_q.push_back(wd);
    if (m_state == 1) m_state = 2;
    else if (rise) begin
      m_state = 1;
      m_q.delete();
    end
    m_vprev = vs;
    sb_q.push_back({de, hs, vs, exp_pix});
    @(posedge clock);
    #1;
    exp_out = sb_q.pop_front();
    check("pixel", 32'({DE, HSYNC, VSYNC, data}), 32'(exp_out));
    check("level", 32'(fifoLevel), 32'(m_q.size()));
    check("uflow", 32'(underflow), 32'(m_uf));
  endtask

  task automatic vsync_pulse();
    step(0, 0, 0, 0, 1, 0, 24'h0);
    step(0, 0, 0, 0, 0, 0, 24'h0);
  endtask

  task automatic push_words(input int n, input int key_at);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1, (i == key_at) ? KEY : 24'(i + 1));
  endtask

  task automatic sweep_row(input int v, input bit valid);
    for (int h = 0; h < HPIX; h++) step(h, v, 1, h == HPIX - 1, 0, valid, 24'hA00000 + 24'(h));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    hCount = '0; vCount = '0; deIn = 0; hsyncIn = 0; vsyncIn = 0; ovlValid = 0; ovlData = '0;
    bgColour = BG; xo = 2; yo = 1; en = 1'b1;
    xOrigin = 12'(xo); yOrigin = 12'(yo); overlayEnable = en;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_zero("reset_init");
    reset = 1'b0;

    // Reset mid-stream, then a vsync pulse
    vsync_pulse();
    push_words(3, -1);
    #3 reset = 1'b1;
    #1 check_zero("reset_mid");
    model_reset();
    @(posedge clock);
    #1;
    check_zero("reset_hold");
    reset = 1'b0;
    step(0, 0, 0, 0, 0, 0, 24'h0);
    vsync_pulse();

    // Basic window
    push_words(8, -1);
    for (int v = 0; v < 3; v++) sweep_row(v, 0);

    // Colour key on word 2
    vsync_pulse();
    push_words(8, 1);
    for (int v = 0; v < 3; v++) sweep_row(v, 0);

    // Full FIFO, then simultaneous pop and push inside the window
    vsync_pulse();
    push_words(11, -1);
    sweep_row(1, 1);

    // Underflow, sticky across the next flush
    vsync_pulse();
    push_words(3, -1);
    sweep_row(1, 0);
    vsync_pulse();

    // Clipped window at the right raster edge, then overlay disabled
    xo = HPIX - 2;
    push_words(8, -1);
    for (int v = 0; v < 3; v++) sweep_row(v, 0);
    en = 1'b0;
    sweep_row(1, 0);
    vsync_pulse();
    step(0, 0, 0, 0, 0, 0, 24'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/overlay_mixer.md
# overlay_mixer

Pixel-rate compositing stage between the raster timing generators and the HDMI transmitter data bus. Buffers overlay pixels streamed from the DDR image reader in a FIFO and substitutes them for the background pixel inside a programmable rectangular window. Colour-keyed pixels are transparent. Sync and DE are re-registered so they stay aligned with the mixed data.

## Interface
- hBusWidth, 12, width of hCount / xOrigin
- vBusWidth, 12, width of vCount / yOrigin
- overlayWidth, 320, overlay image width in pixels (≥1)
- overlayHeight, 240, overlay image height in lines (≥1)
- fifoAddrWidth, 9, FIFO depth = 2**fifoAddrWidth words
- keyColour, 24'hFF00FF, transparent colour key

Ports:
- clock  in  1  pixel clock, rising edge
- reset  in  1  asynchronous, active-high
- hCount  in  hBusWidth  horizontal pixel counter
- vCount  in  vBusWidth  vertical line counter
- deIn / hsyncIn / vsyncIn  in  1 each  raster timing; vsyncIn active-high
- bgColour  in  24  background pixel from the pattern generator
- overlayEnable  in  1  overlay on (slide switch, already synchronised)
- xOrigin  in  hBusWidth  window left column
- yOrigin  in  vBusWidth  window top line
- ovlData  in  24  overlay pixel from the DDR reader
- ovlValid  in  1  ovlData valid
- ovlReady  out  1  FIFO can accept a word
- ovlFrameStart  out  1  one-cycle pulse telling the reader to restart at image offset 0
- DE / HSYNC / VSYNC  out  1 each  delayed timing outputs
- data  out  24  mixed pixel
- fifoLevel  out  fifoAddrWidth+1  words currently buffered
- underflow  out  1  sticky: a window pixel was needed while the FIFO was empty

## Operation
- FSM states:
  - IDLE: entered on reset. Waits for a vsyncIn rising edge, detected against a registered copy vsyncPrev.
  - FLUSH: lasts exactly 1 cycle. Clears FIFO pointers, sets fifoLevel=0 and pulses ovlFrameStart=1. Always goes to RUN.
  - RUN: any vsyncIn rising edge goes to FLUSH.
- A push occurs when ovlValid && ovlReady.
  - ovlReady = (state==RUN) && (fifoLevel < 2**fifoAddrWidth), computed from registered state only.
  - A full FIFO refuses a push even when a pop happens in the same cycle.
- Window test: inWin = overlayEnable && deIn && (xOrigin ≤ hCount < xOrigin+overlayWidth) && (yOrigin ≤ vCount < yOrigin+overlayHeight).
  - Sums are computed at bus width +1 so they cannot wrap. The visible part of a window that extends past the raster edge is clipped.
  - Clipped pixels are never popped. The per-frame FLUSH realigns the stream.
- Pop occurs when inWin && fifoLevel≠0 && state==RUN. The FIFO is show-ahead: the head word is readable in the same cycle it is popped.
- Pixel select:
  - Popped head ≠ keyColour → head word.
  - Popped head == keyColour → bgColour. The word is still consumed.
  - inWin with an empty FIFO → bgColour, no pop, underflow←1.
  - Otherwise → bgColour.
- fifoLevel: +1 on push only, −1 on pop only, unchanged when both or neither occur. The pointers wrap modulo 2**fifoAddrWidth.
- underflow clears only on reset. FLUSH does not clear it.
- A push and a FLUSH in the same cycle is impossible, because ovlReady=0 in FLUSH.

## Timing
- Latency is 1 cycle. DE, HSYNC, VSYNC and data at edge t+1 reflect deIn, hsyncIn, vsyncIn and the selected pixel at edge t.
- Reset values: DE=0, HSYNC=0, VSYNC=0, data=0, ovlReady=0, ovlFrameStart=0, fifoLevel=0, underflow=0, state=IDLE, vsyncPrev=0.
- ovlFrameStart is high for exactly the FLUSH cycle. This is the cycle after the rising-edge sample of vsyncIn.
- A reset asserted mid-frame clears everything asynchronously. Buffered words are discarded. No output is produced from the FIFO until the next vsyncIn rising edge.
- A push is visible in fifoLevel on the next edge. A word pushed at edge t can be popped at edge t+1 at the earliest.
- Throughput is 1 push and 1 pop per cycle.

## Test plan
Bench parameters: overlayWidth=4, overlayHeight=2, fifoAddrWidth=3, xOrigin=2, yOrigin=1, bgColour=24'h000010.

- **Reset then vsync pulse:** reset mid-stream, then raise vsyncIn → all outputs 0 during reset; ovlFrameStart high exactly 1 cycle after the edge; ovlReady goes 1 on the following cycle.
- **Basic window:** push 8 words 24'h000001..24'h000008, then sweep rows 0–2 with deIn=1 → data = bg everywhere except row 1 cols 2–5 = 1..4 and row 2 cols 2–5 = 5..8, one cycle after hCount. fifoLevel returns to 0.
- **Colour key:** push word 2 = 24'hFF00FF → row 1 col 3 outputs 24'h000010; fifoLevel still decrements.
- **Full FIFO:** hold ovlValid=1 with no window → fifoLevel saturates at 8 and ovlReady=0. During a window, pop and push in the same cycle → level stays at 7 or 8 and does not exceed 8.
- **Underflow:** push only 3 words and sweep the window → col 5 of row 1 outputs bg; underflow=1 and it stays 1 across the next FLUSH.
- **Clip and disable:**
  - xOrigin=hPixels−2 → only 2 pixels are popped per line.
  - overlayEnable=0 → no pops; data=bg.
  - The next vsync flushes fifoLevel to 0.
